// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// port and the data port. One transaction is outstanding at a time
// (IDLE -> REQ -> RESP). If the bus stalls, a timeout returns an error response.
// Build option MEM_ARB_RR_EN: round-robin arbitration between the two ports.
// Without it, the data port has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                bus_req_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    output logic                busy_o
);
    localparam int               CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic       {OWN_INSTR, OWN_DATA}   owner_t;

    state_t              r_state, w_state_nxt;
    owner_t              r_owner, w_winner;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_bus_req, r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W/8-1:0] r_bus_be;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_instr_rvalid, r_instr_err, r_data_rvalid, r_data_err;
    logic [DATA_W-1:0]   r_instr_rdata, r_data_rdata;
    logic                w_grant, w_timeout, w_resp_ok;

    // Gated by reset so the combinational grant pulses stay low while reset is asserted
    assign w_grant   = rst_n_i && (r_state == S_IDLE) && (instr_req_i || data_req_i);
    assign w_timeout = TO_EN && (r_state != S_IDLE) && (r_cnt == TO_VAL);
    assign w_resp_ok = (r_state == S_RESP) && bus_rvalid_i;

`ifdef MEM_ARB_RR_EN
    owner_t r_last_winner;

    // Remember the most recent grant so that contention alternates between the ports
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     r_last_winner <= OWN_INSTR;
        else if (w_grant) r_last_winner <= w_winner;
    end

    // Contention goes to the port that did not win last; a lone requester always wins
    always_comb begin
        w_winner = OWN_INSTR;
        if (instr_req_i && data_req_i)
            w_winner = (r_last_winner == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        else if (data_req_i)
            w_winner = OWN_DATA;
    end
`else
    // Fixed priority: data beats instruction fetch
    always_comb begin
        w_winner = data_req_i ? OWN_DATA : OWN_INSTR;
    end
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; a valid response takes precedence over a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_timeout)      w_state_nxt = S_IDLE;
                else if (bus_gnt_i) w_state_nxt = S_RESP;
            end
            S_RESP: if (w_resp_ok || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the winning request onto the bus and run the timeout counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner     <= OWN_INSTR;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner   <= w_winner;
                r_cnt     <= '0;
                r_bus_req <= 1'b1;
                if (w_winner == OWN_DATA) begin
                    r_bus_addr  <= data_addr_i;
                    r_bus_we    <= data_we_i;
                    r_bus_be    <= data_be_i;
                    r_bus_wdata <= data_wdata_i;
                end else begin
                    r_bus_addr  <= instr_addr_i;
                    r_bus_we    <= 1'b0;
                    r_bus_be    <= '1;
                    r_bus_wdata <= '0;
                end
            end else begin
                if (r_state != S_IDLE) r_cnt <= r_cnt + CNT_W'(1);
                if (w_timeout || ((r_state == S_REQ) && bus_gnt_i)) r_bus_req <= 1'b0;
            end
        end
    end

    // Route the response (or the timeout error) back to the owner as a one-cycle pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_instr_rvalid <= 1'b0;
            r_instr_err    <= 1'b0;
            r_instr_rdata  <= '0;
            r_data_rvalid  <= 1'b0;
            r_data_err     <= 1'b0;
            r_data_rdata   <= '0;
        end else begin
            r_instr_rvalid <= 1'b0;
            r_instr_err    <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_data_err     <= 1'b0;
            if (w_resp_ok || w_timeout) begin
                if (r_owner == OWN_DATA) begin
                    r_data_rvalid <= 1'b1;
                    r_data_err    <= !w_resp_ok;
                    r_data_rdata  <= w_resp_ok ? bus_rdata_i : '0;
                end else begin
                    r_instr_rvalid <= 1'b1;
                    r_instr_err    <= !w_resp_ok;
                    r_instr_rdata  <= w_resp_ok ? bus_rdata_i : '0;
                end
            end
        end
    end

    assign instr_gnt_o    = w_grant && (w_winner == OWN_INSTR);
    assign data_gnt_o     = w_grant && (w_winner == OWN_DATA);
    assign instr_rvalid_o = r_instr_rvalid;
    assign instr_err_o    = r_instr_err;
    assign instr_rdata_o  = r_instr_rdata;
    assign data_rvalid_o  = r_data_rvalid;
    assign data_err_o     = r_data_err;
    assign data_rdata_o   = r_data_rdata;
    assign bus_req_o      = r_bus_req;
    assign bus_addr_o     = r_bus_addr;
    assign bus_we_o       = r_bus_we;
    assign bus_be_o       = r_bus_be;
    assign bus_wdata_o    = r_bus_wdata;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction-fetch port and data port.
- Sits between the core and the unified memory/interconnect.
- Arbitrates requests and registers the winning request onto the bus with a req/gnt/rvalid handshake.
- Routes the response back to the winner; a timeout counter returns an error response when the bus never completes.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports (byte enables are DATA_W/8 bits).
- TIMEOUT_CYCLES, 255, cycles in REQ+RESP before an error response is forced; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_W  fetch address
- instr_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- instr_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- instr_rdata_o  out  DATA_W  fetch read data
- instr_err_o  out  1  fetch response is a timeout error (qualified by rvalid)
- data_req_i  in  1  load/store request
- data_addr_i  in  ADDR_W  data address
- data_we_i  in  1  1 = store
- data_be_i  in  DATA_W/8  byte enables
- data_wdata_i  in  DATA_W  store data
- data_gnt_o  out  1  data request accepted (1-cycle pulse)
- data_rvalid_o  out  1  data response valid (1-cycle pulse)
- data_rdata_o  out  DATA_W  load data
- data_err_o  out  1  data response is a timeout error
- bus_req_o  out  1  bus request
- bus_addr_o  out  ADDR_W  bus address
- bus_we_o  out  1  bus write enable
- bus_be_o  out  DATA_W/8  bus byte enables
- bus_wdata_o  out  DATA_W  bus write data
- bus_gnt_i  in  1  bus accepted request
- bus_rvalid_i  in  1  bus response valid
- bus_rdata_i  in  DATA_W  bus read data
- busy_o  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset:
  - state = IDLE; all outputs 0; timeout counter 0; owner = INSTR.
  - Round-robin builds only: last_winner = INSTR.
- FSM states: IDLE, REQ, RESP. One outstanding transaction at a time.
- IDLE:
  - If any req_i is high, select the winner.
  - Pulse the winner's gnt_o in that same cycle.
  - Latch addr/we/be/wdata into bus_*_o registers and record owner; next state = REQ.
  - Instruction winner drives bus_we_o = 0 and bus_be_o = all ones.
  - A requester may drop req_i or change its inputs after the gnt cycle.
- REQ:
  - bus_req_o = 1 and bus_* are held stable.
  - On bus_gnt_i: bus_req_o falls next cycle; next state = RESP.
- RESP:
  - On bus_rvalid_i: register bus_rdata_i to owner's rdata_o; pulse owner's rvalid_o for 1 cycle with err_o = 0; next state = IDLE.
  - The non-owner's rvalid_o stays 0.
  - rdata_o holds its last value between responses.
- Latency: gnt pulse at cycle N; bus_req_o high from N+1; response pulse one cycle after bus_rvalid_i. Minimum 4 cycles per transaction.
- Priority, simultaneous requests in IDLE: data wins (fixed priority). The instruction request stays pending and is granted at the next IDLE.
- bus_rvalid_i outside RESP is ignored. The bus guarantees rvalid no earlier than the cycle after gnt.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): pulse owner's rvalid_o with err_o = 1, rdata_o = 0; drop bus_req_o; next state = IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Bus contract: no response after a timeout.
- If bus_rvalid_i and timeout occur in the same cycle, the valid response wins (err_o = 0).
- Reset mid-transaction: immediate return to reset values; no response is issued.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are high in IDLE, the one that is not last_winner wins; last_winner updates on every grant. A lone requester always wins.
- Undefined: fixed data-over-instruction priority; no last_winner register.

Test Plan:
- Single fetch, instr_addr_i = 0x100: instr_gnt_o at cycle 0; bus_req_o with bus_addr_o = 0x100, bus_we_o = 0, bus_be_o = 0xF from cycle 1; bus_gnt_i at cycle 2; bus_rvalid_i with 0xDEADBEEF at cycle 4 -> instr_rvalid_o at cycle 5 with rdata 0xDEADBEEF, err 0.
- Store addr 0x2004, be 0x3, wdata 0x1234 -> bus_we_o = 1, bus_be_o = 0x3, bus_wdata_o = 0x1234; data_rvalid_o pulses after the response; instr_rvalid_o stays 0.
- Both requesting continuously, fixed priority -> data granted first, instr on the next IDLE. With MEM_ARB_RR_EN: grants alternate D, I, D, I.
- Bus never asserts gnt, TIMEOUT_CYCLES = 8 -> 8 cycles after entering REQ, owner's rvalid_o and err_o = 1, rdata 0, bus_req_o = 0, busy_o = 0.
- rst_n_i low while in RESP -> outputs 0 asynchronously; next request after reset is handled normally; a stale bus_rvalid_i in IDLE is ignored.
